// File: rtl/byte_serializer.sv
// ----------------------------------------------------------------------------
// byte_serializer
// Accepts parallel bytes over a valid/ready handshake, buffers them in a
// DEPTH-entry FIFO and emits each byte one bit per clock, MSB first.
// A left-shifting consumer that inserts at bit 0 holds the original byte
// after eight s_valid cycles.
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 2)
//   GAP           idle cycles forced between consecutive bytes (0..15)
// Ports
//   i_clk         single clock, all logic on posedge
//   i_rst         synchronous active-high reset
//   i_in_data     byte to serialize
//   i_in_valid    i_in_data valid
//   o_in_ready    FIFO can accept (transfer on valid && ready at posedge)
//   o_s_out       serial bit, MSB first
//   o_s_valid     o_s_out carries a data bit this cycle
//   o_s_last      current bit is the eighth bit of the byte
//   o_busy        FSM not idle
//   o_fifo_count  bytes held in the FIFO (not counting the shift register)
// ----------------------------------------------------------------------------
module byte_serializer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_in_data,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output logic                       o_s_out,
  output logic                       o_s_valid,
  output logic                       o_s_last,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);

  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam int GAP_M1 = (GAP > 0) ? (GAP - 1) : 0;
  localparam bit HAS_GAP = (GAP > 0);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_M1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [3:0]    r_gap_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [7:0]    w_head;
  logic [1:0]    w_state_nxt;
  logic [7:0]    w_shift_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [3:0]    w_gap_cnt_nxt;

  // Ready depends only on the registered count (and is held low in reset),
  // so a full FIFO refuses a push even when a pop happens the same cycle.
  assign o_in_ready = ~i_rst & (r_count < FULL_CNT);
  assign w_push     = i_in_valid & o_in_ready;
  assign w_nonempty = (r_count != {CW{1'b0}});
  assign w_head     = r_mem[r_rd_ptr];

  // Output decode from registered state
  assign o_s_valid    = (r_state == ST_SHIFT);
  assign o_s_out      = o_s_valid & r_shift[7];
  assign o_s_last     = o_s_valid & (r_bit_cnt == 3'd7);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_fifo_count = r_count;

  // FIFO storage: data only, no reset needed since count/pointers gate reads
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_nonempty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = ST_SHIFT;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_shift_nxt   = {r_shift[6:0], 1'b0};
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (HAS_GAP) begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = 4'd0;
          end else if (w_nonempty) begin
            // back-to-back: next byte loads on the edge that ends this one
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = ST_SHIFT;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        if (r_gap_cnt == GAP_LAST) begin
          if (w_nonempty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = ST_SHIFT;
          end else begin
            w_state_nxt   = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_shift_nxt   = 8'd0;
        w_bit_cnt_nxt = 3'd0;
        w_gap_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Serializer state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_gap_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Upstream feeder for the 8-bit serial shift-in stage. Accepts parallel bytes over a valid/ready handshake, buffers them in a small FIFO, and emits each byte one bit per clock, MSB first, on a single serial line with a bit-valid qualifier and last-bit marker. After eight valid bits, a left-shifting consumer that inserts at bit 0 holds the original byte.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- GAP, 0: idle cycles forced between consecutive bytes; 0..15
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- in_data  input  8  byte to serialize
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at posedge
- s_out  output  1  serial bit, MSB first
- s_valid  output  1  s_out carries a data bit this cycle
- s_last  output  1  current bit is bit 0 (eighth bit) of the byte
- busy  output  1  FSM not in IDLE
- fifo_count  output  $clog2(DEPTH+1)  bytes stored in FIFO (excludes byte in shift register)

## Operation
- Reset (rst high at a posedge): FIFO flushed, fifo_count=0, state=IDLE, shift reg=0, bit counter=0, s_out=0, s_valid=0, s_last=0, busy=0; in_ready=0 while rst is high, 1 afterward.
- in_ready = (fifo_count < DEPTH); combinational from registered count only, never from in_valid.
- Push and pop in the same cycle are allowed when not full; when full, in_ready=0, so no push even if a pop occurs.
- FSM states:
  - IDLE: if fifo_count>0, pop head into shift reg, bit_cnt=0, go SHIFT.
  - SHIFT: each posedge, shift left one bit, bit_cnt+1. At the posedge where bit_cnt==7:
    - if GAP>0, go GAP with gap_cnt=0;
    - else if fifo_count>0, pop the next byte and stay in SHIFT (back-to-back);
    - else go IDLE.
  - GAP: gap_cnt+1 each posedge. At gap_cnt==GAP-1, pop and go SHIFT if fifo_count>0, else go IDLE.
- Outputs:
  - s_out = shift_reg[7] in SHIFT, 0 otherwise.
  - s_valid = (state==SHIFT).
  - s_last = (state==SHIFT && bit_cnt==7).
  - busy = (state!=IDLE).
- Bytes are emitted in push order. No byte is dropped or duplicated.

## Timing
- Push into an empty FIFO with FSM in IDLE at posedge k → pop at posedge k+1 → first bit (MSB) valid in the cycle after k+1.
- Each byte occupies exactly 8 consecutive s_valid cycles; s_last is high only on the 8th.
- GAP=0 with FIFO non-empty: s_valid stays continuously high across byte boundaries.
- GAP=N>0: s_valid is low for exactly N cycles between bytes.
- fifo_count updates at the posedge of push/pop; a simultaneous push and pop leaves it unchanged.
- FIFO pointers wrap modulo DEPTH. Count saturates logically at DEPTH via in_ready, never exceeding it.
- Reset mid-byte aborts the byte: s_valid=0 in the cycle after the reset edge, and buffered bytes are lost.
- in_valid while rst is high is ignored.

## Test plan
- Single byte, GAP=0: push 0xA5 → s_out sequence 1,0,1,0,0,1,0,1 over 8 s_valid cycles, s_last on the 8th; a downstream shift-in register reads 0xA5; busy drops 1 cycle later.
- Back-to-back, GAP=0: push 0x3C, 0xFF on consecutive cycles → 16 contiguous s_valid cycles, bits 00111100 11111111, s_last on cycles 8 and 16.
- Full/backpressure, DEPTH=4, in_valid held with 6 bytes 0x01..0x06:
  - accepts at edges 1–5;
  - fifo_count=4 and in_ready=0 after edge 5;
  - 0x02 is popped at edge 10 and in_ready rises;
  - 0x06 is accepted at edge 11;
  - output order is 0x01..0x06.
- GAP=2: push 0x80, 0x01 → 8 valid bits, then exactly 2 cycles of s_valid=0, then 8 valid bits; s_out=0 during the gap.
- Reset mid-operation: rst high during bit 4 of 0xF0 with 2 bytes queued → next cycle s_valid=0, fifo_count=0, busy=0. A later push of 0x5A serializes correctly with fresh wrap-around pointers.
- Pointer wrap: stream 20 random bytes with random in_valid gaps → the serial output, reassembled, matches the input byte order exactly.
